// File: rtl/scm_stream_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scm_stream_reader_pkg
// Description : Shared types and helpers for the SCM stream reader.
//               - reader_state_e : reader FSM encoding
//               - wrap_inc       : row-address increment with wrap at row_cnt
// Revision    : 1.0 - initial release
// ============================================================================
package scm_stream_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } reader_state_e;

    // Next row address.  The row count need not be a power of two, so the
    // wrap is an explicit compare rather than natural overflow.
    function automatic int unsigned wrap_inc(input int unsigned addr,
                                             input int unsigned row_cnt);
        return ((addr + 32'd1) >= row_cnt) ? 32'd0 : (addr + 32'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/scm_stream_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : scm_stream_reader_if
// Description : Valid/ready stream carrying SCM rows to a consumer.
//               data_o  : row payload      (master -> slave)
//               valid_o : beat valid       (master -> slave)
//               last_o  : final beat mark  (master -> slave)
//               ready_i : consumer ready   (slave  -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface scm_stream_reader_if #(
    parameter int WORD_WIDTH = 25
);
    logic [WORD_WIDTH-1:0] data_o;
    logic                  valid_o;
    logic                  last_o;
    logic                  ready_i;

    modport master (output data_o, output valid_o, output last_o, input ready_i);
    modport slave  (input data_o, input valid_o, input last_o, output ready_i);
endinterface
`default_nettype wire

// File: rtl/scm_stream_reader_skid.sv
`default_nettype none
// ============================================================================
// Module      : scm_stream_skid
// Description : Two-entry valid/ready skid buffer with synchronous flush.
//               Ports: clk, rst (async, active-high), i_flush, i_push,
//               i_data, o_full, o_empty_next, o_data, o_valid, i_ready.
//               o_full depends only on registered state, so the producer's
//               push enable never sees i_ready combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module scm_stream_skid #(
    parameter int WIDTH = 26
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_flush,
    input  wire logic             i_push,
    input  wire logic [WIDTH-1:0] i_data,
    output logic                  o_full,
    output logic                  o_empty_next,
    output logic [WIDTH-1:0]      o_data,
    output logic                  o_valid,
    input  wire logic             i_ready
);

    logic [1:0]       r_count;
    logic [1:0]       w_count_next;
    logic [1:0]       w_wr_idx;
    logic [WIDTH-1:0] r_slot0;     // head entry, always presented on o_data
    logic [WIDTH-1:0] r_slot1;
    logic             w_pop;

    assign o_valid = (r_count != 2'd0);
    assign o_full  = (r_count == 2'd2);
    assign o_data  = r_slot0;
    assign w_pop   = o_valid & i_ready;

    always_comb begin
        w_count_next = r_count;
        if (i_push && !w_pop) begin
            w_count_next = r_count + 2'd1;
        end else if (!i_push && w_pop) begin
            w_count_next = r_count - 2'd1;
        end
        if (i_flush) begin
            w_count_next = 2'd0;
        end
    end

    // Lets the owner finish a burst in the same cycle the last beat leaves.
    assign o_empty_next = (w_count_next == 2'd0);

    // Slot the incoming word lands in after this cycle's pop has shifted.
    assign w_wr_idx = r_count - {1'b0, w_pop};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 2'd0;
            r_slot0 <= '0;
            r_slot1 <= '0;
        end else if (i_flush) begin
            r_count <= 2'd0;
        end else begin
            r_count <= w_count_next;
            if (w_pop && (r_count == 2'd2)) begin
                r_slot0 <= r_slot1;
            end
            if (i_push) begin
                if (w_wr_idx == 2'd0) begin
                    r_slot0 <= i_data;
                end else begin
                    r_slot1 <= i_data;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/scm_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : scm_stream_reader
// Description : Read-side controller for a latch-based 1R1W SCM.  Walks
//               ROW_CNT-modulo addresses from a start row, samples the
//               combinational read data and emits rows as a valid/ready
//               stream with last marking.
//               Ports: clk_i, rst_i (async, active-high), start_i,
//               start_addr_i, len_i, abort_i, busy_o, done_o, scm_raddr_o,
//               scm_rdata_i, strm (stream master: data/valid/last/ready).
// Revision    : 1.0 - initial release
// ============================================================================
module scm_stream_reader
    import scm_stream_reader_pkg::*;
#(
    parameter  int WORD_WIDTH = 25,
    parameter  int ROW_CNT    = 64,
    localparam int ADDR_WIDTH = (ROW_CNT > 1) ? $clog2(ROW_CNT) : 1,
    localparam int LEN_WIDTH  = $clog2(ROW_CNT + 1)
) (
    input  wire logic                  clk_i,
    input  wire logic                  rst_i,
    input  wire logic                  start_i,
    input  wire logic [ADDR_WIDTH-1:0] start_addr_i,
    input  wire logic [LEN_WIDTH-1:0]  len_i,
    input  wire logic                  abort_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [ADDR_WIDTH-1:0]      scm_raddr_o,
    input  wire logic [WORD_WIDTH-1:0] scm_rdata_i,
    scm_stream_reader_if.master        strm
);

    localparam logic [LEN_WIDTH-1:0] c_ROW_CNT_LEN = LEN_WIDTH'(ROW_CNT);
    localparam logic [LEN_WIDTH-1:0] c_LEN_ONE     = LEN_WIDTH'(1);

    reader_state_e         r_state;
    reader_state_e         w_state_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] w_start_addr;
    logic [LEN_WIDTH-1:0]  r_rem;
    logic [LEN_WIDTH-1:0]  w_len;
    logic                  r_done;
    logic                  w_done_set;
    logic                  w_capture;
    logic                  w_load;
    logic                  w_flush;
    logic                  w_buf_full;
    logic                  w_buf_empty_next;
    logic [WORD_WIDTH:0]   w_out_payload;

    // Out-of-range start rows fold back into the array; oversize lengths
    // saturate at one full pass.
    assign w_start_addr = ADDR_WIDTH'(32'(start_addr_i) % ROW_CNT);
    assign w_len        = (32'(len_i) > ROW_CNT) ? c_ROW_CNT_LEN : len_i;

    // ---------------- state register ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start_i && (w_len != '0)) begin
                    w_state_next = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (abort_i) begin
                    w_state_next = ST_IDLE;
                end else if (w_capture && (r_rem == c_LEN_ONE)) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (abort_i || w_buf_empty_next) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ---------------- output / control logic ----------------
    always_comb begin
        w_load     = (r_state == ST_IDLE) && start_i && (w_len != '0);
        w_flush    = (r_state != ST_IDLE) && abort_i;
        // Capture depends only on registered buffer occupancy, never ready_i.
        w_capture  = (r_state == ST_STREAM) && !w_buf_full && !abort_i;
        w_done_set = ((r_state == ST_IDLE) && start_i && (w_len == '0))
                   || w_flush
                   || ((r_state == ST_DRAIN) && w_buf_empty_next);
    end

    // ---------------- address / count / done datapath ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_addr <= '0;
            r_rem  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_done_set;
            if (w_load) begin
                r_addr <= w_start_addr;
                r_rem  <= w_len;
            end else if (w_flush) begin
                r_rem  <= '0;
            end else if (w_capture) begin
                r_addr <= ADDR_WIDTH'(wrap_inc(32'(r_addr), ROW_CNT));
                r_rem  <= r_rem - c_LEN_ONE;
            end
        end
    end

    scm_stream_skid #(
        .WIDTH (WORD_WIDTH + 1)
    ) u_skid (
        .clk          (clk_i),
        .rst          (rst_i),
        .i_flush      (w_flush),
        .i_push       (w_capture),
        .i_data       ({(r_rem == c_LEN_ONE), scm_rdata_i}),
        .o_full       (w_buf_full),
        .o_empty_next (w_buf_empty_next),
        .o_data       (w_out_payload),
        .o_valid      (strm.valid_o),
        .i_ready      (strm.ready_i)
    );

    assign strm.data_o = w_out_payload[WORD_WIDTH-1:0];
    assign strm.last_o = w_out_payload[WORD_WIDTH];
    assign busy_o      = (r_state != ST_IDLE);
    assign done_o      = r_done;
    assign scm_raddr_o = r_addr;

endmodule
`default_nettype wire

// File: tb/tb_scm_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_scm_stream_reader
// Description : Directed self-checking bench for scm_stream_reader with a
//               64-row instance (SCM model in a writable array) and a 48-row
//               instance (read-only SCM model) for non-power-of-two wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scm_stream_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // ---------------- 64-row DUT ----------------
    logic        rst;
    logic        start;
    logic [5:0]  start_addr;
    logic [6:0]  len;
    logic        abort;
    logic        busy, done;
    logic [5:0]  raddr;
    logic [24:0] rdata;
    logic [24:0] mem [0:63];

    assign rdata = mem[raddr];

    scm_stream_reader_if #(.WORD_WIDTH(25)) s64 ();

    scm_stream_reader #(.WORD_WIDTH(25), .ROW_CNT(64)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .start_addr_i(start_addr),
        .len_i(len), .abort_i(abort), .busy_o(busy), .done_o(done),
        .scm_raddr_o(raddr), .scm_rdata_i(rdata), .strm(s64)
    );

    // ---------------- 48-row DUT ----------------
    logic        start48;
    logic [5:0]  addr48;
    logic [5:0]  len48;
    logic        abort48;
    logic        busy48, done48;
    logic [5:0]  raddr48;
    logic [24:0] rdata48;

    scm_stream_reader_if #(.WORD_WIDTH(25)) s48 ();

    scm_stream_reader #(.WORD_WIDTH(25), .ROW_CNT(48)) dut48 (
        .clk_i(clk), .rst_i(rst), .start_i(start48), .start_addr_i(addr48),
        .len_i(len48), .abort_i(abort48), .busy_o(busy48), .done_o(done48),
        .scm_raddr_o(raddr48), .scm_rdata_i(rdata48), .strm(s48)
    );

    function automatic logic [24:0] row_val(input int r);
        return 25'(r * 689 + 341);
    endfunction

    function automatic logic [24:0] row48_val(input int r);
        return 25'(r * 4099 + 17);
    endfunction

    assign rdata48 = row48_val(int'(raddr48));

    // Beat capture area filled by collect
    logic [24:0] got_data [0:127];
    logic        got_last [0:127];
    int          got_n;
    bit          got_done;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Records handshaken beats until done_o is seen or the budget expires.
    task automatic collect(input bit sel48, input int max_cycles);
        got_n    = 0;
        got_done = 1'b0;
        for (int c = 0; c < max_cycles; c++) begin
            if (sel48 ? (s48.valid_o && s48.ready_i) : (s64.valid_o && s64.ready_i)) begin
                if (got_n < 128) begin
                    got_data[got_n] = sel48 ? s48.data_o : s64.data_o;
                    got_last[got_n] = sel48 ? s48.last_o : s64.last_o;
                end
                got_n++;
            end
            if (sel48 ? done48 : done) begin
                got_done = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start_addr = '0; len = '0; abort = 1'b0;
        start48 = 1'b0; addr48 = '0; len48 = '0; abort48 = 1'b0;
        s64.ready_i = 1'b0; s48.ready_i = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got=%b exp=0", done); end
        tests_run++; if (s64.valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got=%b exp=0", s64.valid_o); end
        tests_run++; if (s64.last_o !== 1'b0) begin tests_failed++; $display("FAIL reset_last got=%b exp=0", s64.last_o); end
        tests_run++; if (s64.data_o !== 25'd0) begin tests_failed++; $display("FAIL reset_data got=%h exp=0", s64.data_o); end
        tests_run++; if (raddr !== 6'd0) begin tests_failed++; $display("FAIL reset_raddr got=%0d exp=0", raddr); end
    endtask

    task automatic test_basic();
        start = 1'b1; start_addr = 6'd5; len = 7'd4; s64.ready_i = 1'b1;
        tick();                                   // cycle 1
        start = 1'b0;
        tests_run++; if (raddr !== 6'd5) begin tests_failed++; $display("FAIL basic_raddr got=%0d exp=5", raddr); end
        tests_run++; if (s64.valid_o !== 1'b0) begin tests_failed++; $display("FAIL basic_valid_c1 got=%b exp=0", s64.valid_o); end
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL basic_busy got=%b exp=1", busy); end
        for (int i = 0; i < 4; i++) begin
            tick();                               // cycles 2..5
            tests_run++;
            if (s64.valid_o !== 1'b1 || s64.data_o !== row_val(5 + i) || s64.last_o !== (i == 3)) begin
                tests_failed++;
                $display("FAIL basic_beat%0d got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                         i, s64.valid_o, s64.data_o, s64.last_o, row_val(5 + i), (i == 3));
            end
        end
        tick();                                   // cycle 6
        tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL basic_done got=%b exp=1", done); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL basic_busy_end got=%b exp=0", busy); end
        tests_run++; if (s64.valid_o !== 1'b0) begin tests_failed++; $display("FAIL basic_valid_end got=%b exp=0", s64.valid_o); end
        tick();
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
    endtask

    task automatic test_wrap();
        int exp_rows64 [4] = '{62, 63, 0, 1};
        int exp_rows48 [4] = '{46, 47, 0, 1};
        start = 1'b1; start_addr = 6'd62; len = 7'd4; s64.ready_i = 1'b1;
        tick();
        start = 1'b0;
        collect(1'b0, 20);
        tests_run++; if (got_n !== 4 || !got_done) begin tests_failed++; $display("FAIL wrap64_count got=%0d done=%b exp=4 done=1", got_n, got_done); end
        for (int i = 0; i < 4 && i < got_n; i++) begin
            tests_run++;
            if (got_data[i] !== row_val(exp_rows64[i]) || got_last[i] !== (i == 3)) begin
                tests_failed++;
                $display("FAIL wrap64_beat%0d got d=%h l=%b exp d=%h l=%b", i, got_data[i], got_last[i], row_val(exp_rows64[i]), (i == 3));
            end
        end
        tick();
        start48 = 1'b1; addr48 = 6'd46; len48 = 6'd4;
        tick();
        start48 = 1'b0;
        collect(1'b1, 20);
        tests_run++; if (got_n !== 4 || !got_done) begin tests_failed++; $display("FAIL wrap48_count got=%0d done=%b exp=4 done=1", got_n, got_done); end
        for (int i = 0; i < 4 && i < got_n; i++) begin
            tests_run++;
            if (got_data[i] !== row48_val(exp_rows48[i]) || got_last[i] !== (i == 3)) begin
                tests_failed++;
                $display("FAIL wrap48_beat%0d got d=%h l=%b exp d=%h l=%b", i, got_data[i], got_last[i], row48_val(exp_rows48[i]), (i == 3));
            end
        end
        tick();
        // Start row 50 on a 48-row array folds to row 2
        start48 = 1'b1; addr48 = 6'd50; len48 = 6'd2;
        tick();
        start48 = 1'b0;
        collect(1'b1, 20);
        tests_run++;
        if (got_n !== 2 || got_data[0] !== row48_val(2) || got_data[1] !== row48_val(3)) begin
            tests_failed++;
            $display("FAIL mod48_rows got n=%0d d0=%h d1=%h exp n=2 d0=%h d1=%h",
                     got_n, got_data[0], got_data[1], row48_val(2), row48_val(3));
        end
        tick();
    endtask

    task automatic test_stall();
        logic [4:0]  pat = 5'b11001;              // cycles 2..6: 1,0,0,1,1
        logic [24:0] prev_d = '0;
        logic        prev_l = 1'b0;
        bit          prev_stall = 1'b0;
        bit          seen_done = 1'b0;
        int          n = 0;
        logic [24:0] beats [0:7];
        logic        lasts [0:7];
        start = 1'b1; start_addr = 6'd10; len = 7'd3; s64.ready_i = 1'b1;
        tick();
        start = 1'b0;
        tick();                                   // cycle 2
        for (int c = 0; c < 12; c++) begin
            s64.ready_i = (c < 5) ? pat[c] : 1'b1;
            if (prev_stall) begin
                tests_run++;
                if (s64.valid_o !== 1'b1 || s64.data_o !== prev_d || s64.last_o !== prev_l) begin
                    tests_failed++;
                    $display("FAIL stall_hold c%0d got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                             c, s64.valid_o, s64.data_o, s64.last_o, prev_d, prev_l);
                end
            end
            prev_stall = 1'b0;
            if (s64.valid_o) begin
                if (s64.ready_i) begin
                    if (n < 8) begin beats[n] = s64.data_o; lasts[n] = s64.last_o; end
                    n++;
                end else begin
                    prev_stall = 1'b1; prev_d = s64.data_o; prev_l = s64.last_o;
                end
            end
            if (done) begin seen_done = 1'b1; break; end
            tick();
        end
        tests_run++; if (n !== 3 || !seen_done) begin tests_failed++; $display("FAIL stall_count got=%0d done=%b exp=3 done=1", n, seen_done); end
        for (int i = 0; i < 3 && i < n; i++) begin
            tests_run++;
            if (beats[i] !== row_val(10 + i) || lasts[i] !== (i == 2)) begin
                tests_failed++;
                $display("FAIL stall_beat%0d got d=%h l=%b exp d=%h l=%b", i, beats[i], lasts[i], row_val(10 + i), (i == 2));
            end
        end
        s64.ready_i = 1'b1;
        tick();
    endtask

    task automatic test_len_edges();
        bit saw_valid = 1'b0;
        int bad = 0;
        start = 1'b1; start_addr = 6'd3; len = 7'd0;
        tick();
        start = 1'b0;
        tests_run++; if (done !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("FAIL zero_done got done=%b busy=%b exp done=1 busy=0", done, busy); end
        for (int c = 0; c < 4; c++) begin
            if (s64.valid_o) saw_valid = 1'b1;
            tick();
        end
        tests_run++; if (saw_valid || done !== 1'b0) begin tests_failed++; $display("FAIL zero_quiet got valid_seen=%b done=%b exp 0 0", saw_valid, done); end
        // Length 100 saturates at 64 rows
        start = 1'b1; start_addr = 6'd0; len = 7'd100; s64.ready_i = 1'b1;
        tick();
        start = 1'b0;
        collect(1'b0, 200);
        tests_run++; if (got_n !== 64 || !got_done) begin tests_failed++; $display("FAIL clamp_count got=%0d done=%b exp=64 done=1", got_n, got_done); end
        for (int i = 0; i < 64 && i < got_n; i++) begin
            if (got_data[i] !== row_val(i) || got_last[i] !== (i == 63)) bad++;
        end
        tests_run++; if (bad !== 0) begin tests_failed++; $display("FAIL clamp_beats got=%0d bad beats exp=0", bad); end
        tick();
    endtask

    task automatic test_abort();
        start = 1'b1; start_addr = 6'd20; len = 7'd10; s64.ready_i = 1'b1;
        tick();                                   // cycle 1
        start = 1'b0;
        tick();                                   // cycle 2
        tests_run++; if (s64.valid_o !== 1'b1 || s64.data_o !== row_val(20)) begin tests_failed++; $display("FAIL abort_beat0 got v=%b d=%h exp v=1 d=%h", s64.valid_o, s64.data_o, row_val(20)); end
        tick();                                   // cycle 3
        tests_run++; if (s64.valid_o !== 1'b1 || s64.data_o !== row_val(21)) begin tests_failed++; $display("FAIL abort_beat1 got v=%b d=%h exp v=1 d=%h", s64.valid_o, s64.data_o, row_val(21)); end
        tick();                                   // cycle 4: two handshakes done
        s64.ready_i = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0;
        tests_run++;
        if (s64.valid_o !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_flush got v=%b done=%b busy=%b exp v=0 done=1 busy=0", s64.valid_o, done, busy);
        end
        s64.ready_i = 1'b1;
        tick();
        tests_run++; if (done !== 1'b0 || s64.valid_o !== 1'b0) begin tests_failed++; $display("FAIL abort_after got done=%b v=%b exp 0 0", done, s64.valid_o); end
        start = 1'b1; start_addr = 6'd30; len = 7'd2;
        tick();
        start = 1'b0;
        collect(1'b0, 20);
        tests_run++;
        if (got_n !== 2 || got_data[0] !== row_val(30) || got_data[1] !== row_val(31) || got_last[0] !== 1'b0 || got_last[1] !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort_restart got n=%0d d0=%h d1=%h exp n=2 d0=%h d1=%h", got_n, got_data[0], got_data[1], row_val(30), row_val(31));
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bit saw_done = 1'b0;
        start = 1'b1; start_addr = 6'd0; len = 7'd10; s64.ready_i = 1'b0;
        tick();
        start = 1'b0;
        tick(); tick();
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (busy !== 1'b0 || s64.valid_o !== 1'b0 || s64.last_o !== 1'b0 || s64.data_o !== 25'd0 || raddr !== 6'd0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_async got busy=%b v=%b l=%b d=%h ra=%0d done=%b exp all 0",
                     busy, s64.valid_o, s64.last_o, s64.data_o, raddr, done);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        s64.ready_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (done || busy || s64.valid_o) saw_done = 1'b1;
        end
        tests_run++; if (saw_done) begin tests_failed++; $display("FAIL rst_no_done got activity=1 exp=0"); end
    endtask

    task automatic test_coherency();
        logic [24:0] old40;
        start = 1'b1; start_addr = 6'd40; len = 7'd6; s64.ready_i = 1'b0;
        tick();
        start = 1'b0;
        tick(); tick();                           // rows 40,41 buffered, capture stalled
        old40   = mem[40];
        mem[40] = 25'h1ABCDE;
        mem[45] = 25'h0F0F0F;
        s64.ready_i = 1'b1;
        collect(1'b0, 30);
        tests_run++; if (got_n !== 6) begin tests_failed++; $display("FAIL coh_count got=%0d exp=6", got_n); end
        tests_run++; if (got_data[0] !== old40) begin tests_failed++; $display("FAIL coh_buffered got=%h exp=%h", got_data[0], old40); end
        tests_run++; if (got_data[4] !== row_val(44)) begin tests_failed++; $display("FAIL coh_row44 got=%h exp=%h", got_data[4], row_val(44)); end
        tests_run++; if (got_data[5] !== 25'h0F0F0F || got_last[5] !== 1'b1) begin tests_failed++; $display("FAIL coh_new got d=%h l=%b exp d=0f0f0f l=1", got_data[5], got_last[5]); end
        mem[40] = row_val(40);
        mem[45] = row_val(45);
        tick();
    endtask

    initial begin
        for (int r = 0; r < 64; r++) mem[r] = row_val(r);
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_len_edges();
        test_abort();
        test_reset_mid();
        test_coherency();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
